// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matmul dot-product scheduler.
//   state_t  : scheduler FSM states (IDLE, ISSUE, DRAIN)
//   tag_t    : generic in-flight tag {valid, last, row, col} at maximum index width
//   idx_w()  : index width for a dimension of n entries (minimum 1 bit)
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int TAG_IDX_MAX_W = 16;

  typedef struct packed {
    logic                     valid;
    logic                     last;
    logic [TAG_IDX_MAX_W-1:0] row;
    logic [TAG_IDX_MAX_W-1:0] col;
  } tag_t;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int pipe_depth(input int rd_latency, input int dot_latency);
    return rd_latency + dot_latency;
  endfunction

endpackage

// File: rtl/matmul_dot_sched_if.sv
// Command / operand-buffer / result bundle of the dot-product scheduler.
//   master : scheduler side (drives busy/done, read address, result tag)
//   slave  : command issuer / consumer side
// With MATMUL_SCHED_PERF_EN defined the bundle also carries perf_cycles and
// perf_stalls.
interface matmul_dot_sched_if #(
  parameter int ROW_W = 2,
  parameter int COL_W = 2
);
  logic             start;
  logic             hold;
  logic             busy;
  logic             done;
  logic             rd_en;
  logic [ROW_W-1:0] rd_row;
  logic [COL_W-1:0] rd_col;
  logic             res_valid;
  logic [ROW_W-1:0] res_row;
  logic [COL_W-1:0] res_col;
`ifdef MATMUL_SCHED_PERF_EN
  logic [31:0]      perf_cycles;
  logic [31:0]      perf_stalls;
`endif

  modport master (
    input  start, hold,
    output busy, done, rd_en, rd_row, rd_col, res_valid, res_row, res_col
`ifdef MATMUL_SCHED_PERF_EN
    , output perf_cycles, perf_stalls
`endif
  );

  modport slave (
    output start, hold,
    input  busy, done, rd_en, rd_row, rd_col, res_valid, res_row, res_col
`ifdef MATMUL_SCHED_PERF_EN
    , input perf_cycles, perf_stalls
`endif
  );

endinterface

// File: rtl/matmul_tag_delay.sv
// D-stage tag shift register matching the operand read + vec_dot latency.
//   clk, rst : clock, asynchronous active-high reset (clears every stage)
//   tag_i    : tag entering the pipeline this cycle
//   tag_o    : tag of the vec_dot output present this cycle (D cycles later)
module matmul_tag_delay #(
  parameter int  D      = 5,
  parameter type elem_t = matmul_pkg::tag_t
) (
  input  logic  clk,
  input  logic  rst,
  input  elem_t tag_i,
  output elem_t tag_o
);

  elem_t stage_q [D];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < D; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < D; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[D-1];

endmodule

// File: rtl/matmul_dot_sched.sv
// Scheduler that walks all (row, col) pairs of a ROWS x COLS result through a
// shared pipelined vec_dot unit, row-major with the column index inner.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : matmul_dot_sched_if.master (start/hold in; busy, done, read
//              address and result tag out)
// Optional: MATMUL_SCHED_PERF_EN adds saturating perf_cycles/perf_stalls.
//
// state | meaning
// IDLE  | waiting for start, counters at 0
// ISSUE | one pair per cycle unless hold
// DRAIN | all pairs issued, waiting for the last tag to leave the pipeline
module matmul_dot_sched
  import matmul_pkg::*;
#(
  parameter int ROWS        = 4,
  parameter int COLS        = 4,
  parameter int RD_LATENCY  = 1,
  parameter int DOT_LATENCY = 4
) (
  input logic              clk,
  input logic              rst,
  matmul_dot_sched_if.master bus
);

  localparam int ROW_W = idx_w(ROWS);
  localparam int COL_W = idx_w(COLS);
  localparam int D     = pipe_depth(RD_LATENCY, DOT_LATENCY);

  typedef struct packed {
    logic             valid;
    logic             last;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } sched_tag_t;

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             issue;
  logic             last_pair;
  logic             done_w;
  sched_tag_t       tag_in, tag_out;

  assign last_pair = (row_q == ROW_W'(ROWS - 1)) && (col_q == COL_W'(COLS - 1));
  assign done_w    = tag_out.valid && tag_out.last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ISSUE;
          row_d   = '0;
          col_d   = '0;
        end
      end
      ISSUE: begin
        if (!bus.hold) begin
          issue = 1'b1;
          if (col_q == COL_W'(COLS - 1)) begin
            col_d = '0;
            // Final pair rewinds the counters so the address reads 0 once idle.
            if (last_pair) begin
              row_d   = '0;
              state_d = DRAIN;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (done_w) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Idle slots enter the pipeline as all-zero tags so bubbles stay invalid.
  always_comb begin
    tag_in = '0;
    if (issue) begin
      tag_in.valid = 1'b1;
      tag_in.last  = last_pair;
      tag_in.row   = row_q;
      tag_in.col   = col_q;
    end
  end

  matmul_tag_delay #(
    .D      (D),
    .elem_t (sched_tag_t)
  ) u_tag_delay (
    .clk   (clk),
    .rst   (rst),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_w;
  assign bus.rd_en     = issue;
  assign bus.rd_row    = row_q;
  assign bus.rd_col    = col_q;
  assign bus.res_valid = tag_out.valid;
  assign bus.res_row   = tag_out.row;
  assign bus.res_col   = tag_out.col;

`ifdef MATMUL_SCHED_PERF_EN
  logic [31:0] perf_cycles_q, perf_stalls_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else if ((state_q == IDLE) && bus.start) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      if ((state_q != IDLE) && (perf_cycles_q != '1))
        perf_cycles_q <= perf_cycles_q + 32'd1;
      if ((state_q == ISSUE) && bus.hold && (perf_stalls_q != '1))
        perf_stalls_q <= perf_stalls_q + 32'd1;
    end
  end

  assign bus.perf_cycles = perf_cycles_q;
  assign bus.perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_matmul_dot_sched.sv
// Bench for matmul_dot_sched: a 2x3 instance (A) and a 1x1 instance (B) share
// start/hold/rst. Cycle-mask vectors, a mid-pass reset sequence, and a random
// run against a queue-based reference model of instance A.
module tb_matmul_dot_sched;

  localparam int A_ROWS = 2;
  localparam int A_COLS = 3;
  localparam int B_ROWS = 1;
  localparam int B_COLS = 1;
  localparam int RDL    = 1;
  localparam int DOTL   = 4;
  localparam int D      = RDL + DOTL;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
  logic hold  = 1'b0;

  always #5 clk = ~clk;

  matmul_dot_sched_if #(.ROW_W(1), .COL_W(2)) ifa ();
  matmul_dot_sched_if #(.ROW_W(1), .COL_W(1)) ifb ();

  assign ifa.start = start;
  assign ifa.hold  = hold;
  assign ifb.start = start;
  assign ifb.hold  = hold;

  matmul_dot_sched #(.ROWS(A_ROWS), .COLS(A_COLS), .RD_LATENCY(RDL), .DOT_LATENCY(DOTL))
    dut_a (.clk(clk), .rst(rst), .bus(ifa.master));
  matmul_dot_sched #(.ROWS(B_ROWS), .COLS(B_COLS), .RD_LATENCY(RDL), .DOT_LATENCY(DOTL))
    dut_b (.clk(clk), .rst(rst), .bus(ifb.master));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    hold  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    bit          sel_b;
    logic [31:0] start_m;
    logic [31:0] hold_m;
    logic [31:0] rden_m;
    logic [31:0] resv_m;
    logic [31:0] busy_m;
    logic [31:0] done_m;
    int          perf_cyc;
    int          perf_stl;
  } vec_t;

  vec_t vecs [4];

  // Vector runner: cycle 0 is the first cycle after entry; bit c of each mask
  // is the input/expectation for cycle c.
  task automatic run_vec(input int idx, input bit with_reset);
    vec_t v;
    int   nr, nc, ik, rk;
    int   o_row, o_col, o_rrow, o_rcol;
    logic o_rden, o_resv, o_busy, o_done;
    v  = vecs[idx];
    nr = v.sel_b ? B_ROWS : A_ROWS;
    nc = v.sel_b ? B_COLS : A_COLS;
    ik = 0;
    rk = 0;
    if (with_reset) do_reset();
    for (int c = 0; c < 32; c++) begin
      start = v.start_m[c];
      hold  = v.hold_m[c];
      #1;
      o_rden = v.sel_b ? ifb.rd_en     : ifa.rd_en;
      o_resv = v.sel_b ? ifb.res_valid : ifa.res_valid;
      o_busy = v.sel_b ? ifb.busy      : ifa.busy;
      o_done = v.sel_b ? ifb.done      : ifa.done;
      o_row  = v.sel_b ? int'(ifb.rd_row)  : int'(ifa.rd_row);
      o_col  = v.sel_b ? int'(ifb.rd_col)  : int'(ifa.rd_col);
      o_rrow = v.sel_b ? int'(ifb.res_row) : int'(ifa.res_row);
      o_rcol = v.sel_b ? int'(ifb.res_col) : int'(ifa.res_col);
      check($sformatf("vec%0d ctl c%0d {rd_en,res_valid,busy,done}", idx, c),
            {60'd0, o_rden, o_resv, o_busy, o_done},
            {60'd0, v.rden_m[c], v.resv_m[c], v.busy_m[c], v.done_m[c]});
      if (v.rden_m[c]) begin
        check($sformatf("vec%0d rd addr c%0d", idx, c), {o_row, o_col}, {ik / nc, ik % nc});
        ik = (ik + 1) % (nr * nc);
      end
      if (v.resv_m[c]) begin
        check($sformatf("vec%0d res tag c%0d", idx, c), {o_rrow, o_rcol}, {rk / nc, rk % nc});
        rk = (rk + 1) % (nr * nc);
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    hold  = 1'b0;
`ifdef MATMUL_SCHED_PERF_EN
    check($sformatf("vec%0d perf_cycles", idx),
          v.sel_b ? ifb.perf_cycles : ifa.perf_cycles, v.perf_cyc);
    check($sformatf("vec%0d perf_stalls", idx),
          v.sel_b ? ifb.perf_stalls : ifa.perf_stalls, v.perf_stl);
`endif
  endtask

  // Reference model for instance A: a pass issues N pairs in order, each result
  // appears exactly D cycles after its issue.
  typedef struct {
    int due;
    int row;
    int col;
    bit last;
  } pend_t;

  pend_t       q[$];
  int          cyc;
  int          m_issued;
  bit          m_busy;
  logic [31:0] m_pc, m_ps;

  task automatic run_random(input int ncyc);
    int   n;
    bit   r_rst, issuing, e_rden, front, e_done;
    int   e_row, e_col;
    n        = A_ROWS * A_COLS;
    cyc      = 0;
    m_issued = 0;
    m_busy   = 0;
    m_pc     = '0;
    m_ps     = '0;
    q.delete();
    do_reset();
    for (int k = 0; k < ncyc; k++) begin
      r_rst = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 7) == 0);
      hold  = ($urandom_range(0, 2) == 0);
      rst   = r_rst;
      #1;
      if (r_rst) begin
        check($sformatf("rnd reset outputs k%0d", k),
              {ifa.rd_en, ifa.res_valid, ifa.busy, ifa.done, ifa.rd_row, ifa.rd_col,
               ifa.res_row, ifa.res_col}, '0);
        q.delete();
        m_busy   = 0;
        m_issued = 0;
        m_pc     = '0;
        m_ps     = '0;
`ifdef MATMUL_SCHED_PERF_EN
        check($sformatf("rnd reset perf k%0d", k), {ifa.perf_cycles, ifa.perf_stalls}, '0);
`endif
      end else begin
        issuing = m_busy && (m_issued < n);
        e_rden  = issuing && !hold;
        e_row   = issuing ? m_issued / A_COLS : 0;
        e_col   = issuing ? m_issued % A_COLS : 0;
        front   = (q.size() > 0) && (q[0].due == cyc);
        e_done  = front && q[0].last;
        check($sformatf("rnd ctl k%0d {rd_en,res_valid,busy,done}", k),
              {ifa.rd_en, ifa.res_valid, ifa.busy, ifa.done},
              {e_rden, front, m_busy, e_done});
        check($sformatf("rnd rd addr k%0d", k), {int'(ifa.rd_row), int'(ifa.rd_col)}, {e_row, e_col});
        if (front)
          check($sformatf("rnd res tag k%0d", k), {int'(ifa.res_row), int'(ifa.res_col)},
                {q[0].row, q[0].col});
`ifdef MATMUL_SCHED_PERF_EN
        check($sformatf("rnd perf k%0d", k), {ifa.perf_cycles, ifa.perf_stalls}, {m_pc, m_ps});
`endif
        if (!m_busy) begin
          if (start) begin
            m_busy   = 1;
            m_issued = 0;
            m_pc     = '0;
            m_ps     = '0;
          end
        end else begin
          if (m_pc != '1) m_pc = m_pc + 1;
          if (issuing && hold && m_ps != '1) m_ps = m_ps + 1;
          if (e_rden) begin
            q.push_back('{due: cyc + D, row: e_row, col: e_col, last: (m_issued == n - 1)});
            m_issued++;
          end
          if (front) void'(q.pop_front());
          if (e_done) m_busy = 0;
        end
      end
      cyc++;
      @(posedge clk);
      #1;
      rst = 1'b0;
    end
    start = 1'b0;
    hold  = 1'b0;
  endtask

  initial begin
    vecs[0] = '{sel_b: 0, start_m: 32'h1, hold_m: 32'h0, rden_m: 32'h7E, resv_m: 32'hFC0,
                busy_m: 32'hFFE, done_m: 32'h800, perf_cyc: 11, perf_stl: 0};
    vecs[1] = '{sel_b: 0, start_m: 32'h1, hold_m: 32'hC, rden_m: 32'h1F2, resv_m: 32'h3E40,
                busy_m: 32'h3FFE, done_m: 32'h2000, perf_cyc: 13, perf_stl: 2};
    vecs[2] = '{sel_b: 0, start_m: 32'h1809, hold_m: 32'h0, rden_m: 32'h7E07E,
                resv_m: 32'hFC0FC0, busy_m: 32'hFFEFFE, done_m: 32'h800800,
                perf_cyc: 11, perf_stl: 0};
    vecs[3] = '{sel_b: 1, start_m: 32'h1, hold_m: 32'h0, rden_m: 32'h2, resv_m: 32'h40,
                busy_m: 32'h7E, done_m: 32'h40, perf_cyc: 6, perf_stl: 0};

    do_reset();
    #1;
    check("reset outputs A",
          {ifa.rd_en, ifa.res_valid, ifa.busy, ifa.done, ifa.rd_row, ifa.rd_col,
           ifa.res_row, ifa.res_col}, '0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) run_vec(i, 1'b1);

    // Mid-pass asynchronous reset at cycle 4, then a clean pass with no reset.
    do_reset();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("pre-abort rd_en at cycle 4", ifa.rd_en, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async abort outputs",
          {ifa.rd_en, ifa.res_valid, ifa.busy, ifa.done, ifa.rd_row, ifa.rd_col,
           ifa.res_row, ifa.res_col}, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      check($sformatf("post-abort quiet c%0d", c),
            {ifa.res_valid, ifa.done, ifa.busy, ifa.rd_en}, '0);
      @(posedge clk);
      #1;
    end
    run_vec(0, 1'b0);

    run_random(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matmul_dot_sched.md
Name: matmul_dot_sched

Overview:
- Sequencer that drives one shared, free-running pipelined vec_dot unit over all (row, col) pairs of an ROWS x COLS result matrix.
- Issues operand-buffer read addresses: a row of lhs and a column of rhs (pre-transposed).
- Tracks in-flight dot products through a tag delay line matched to the pipeline depth.
- Emits a result-valid strobe with the (row, col) tag of the vec_dot output currently present.
- Sits between the matmul top-level command interface and the lhs/rhs operand buffers + vec_dot.

Parameters:
- ROWS, 4, result rows (lhs row count), >=1
- COLS, 4, result columns (rhs column count), >=1
- RD_LATENCY, 1, operand-buffer read latency in cycles (address to data at vec_dot input), >=0
- DOT_LATENCY, 4, vec_dot input-to-output latency in cycles, >=1
- ROW_W, max(1,$clog2(ROWS)), row index width (derived localparam)
- COL_W, max(1,$clog2(COLS)), column index width (derived localparam)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  begin a full matrix pass; sampled only in IDLE
- hold  in  1  pause issue (upstream not ready); in-flight work keeps draining
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse coinciding with the last res_valid
- rd_en  out  1  operand-buffer read strobe (one dot issued)
- rd_row  out  ROW_W  lhs row address
- rd_col  out  COL_W  rhs column address
- res_valid  out  1  vec_dot output is a real result this cycle
- res_row  out  ROW_W  row tag of the result
- res_col  out  COL_W  column tag of the result

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; delay line cleared.
- Reset mid-pass: aborts immediately, in-flight tags discarded, no done.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE -> ISSUE when start=1.
  - ISSUE -> DRAIN in the cycle the final pair (ROWS-1, COLS-1) issues.
  - DRAIN -> IDLE in the cycle the last tag exits (done=1 that cycle).
  - start in ISSUE/DRAIN is ignored (not queued).
- busy=1 in ISSUE and DRAIN, including the done cycle; 0 in the cycle after done.
- Issue order: row-major, column inner.
  - rd_en = (state==ISSUE) && !hold.
  - On an issue: col increments; at COLS-1 it wraps to 0 and row increments.
  - hold=1: no issue and counters frozen; hold in IDLE/DRAIN has no effect.
- rd_row/rd_col always show the current counters. They are meaningful only when rd_en=1 and are 0 in IDLE.
- Tag pipeline:
  - Depth D = RD_LATENCY + DOT_LATENCY.
  - An issue at cycle t produces res_valid at cycle t+D with the same row/col.
  - Bubbles created by hold propagate as res_valid=0.
- Last-result detection: DRAIN ends when the delay line holds no valid tags and the final tag was output that cycle. done = res_valid && last-tag flag, where the last-tag flag is carried in the delay line.
- ROWS=1, COLS=1: single issue, ISSUE->DRAIN after one cycle; done at start-accept cycle + 1 + D.
- Back-to-back passes: start asserted in the cycle done is high is ignored. Earliest restart is start sampled in the first IDLE cycle.

Optional Feature:
- Macro: MATMUL_SCHED_PERF_EN.
- Defined adds outputs perf_cycles[31:0] and perf_stalls[31:0].
  - perf_cycles counts busy cycles.
  - perf_stalls counts ISSUE cycles with hold=1.
  - Both clear on an accepted start (and on rst), hold their value after done, and saturate at all-ones.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package matmul_pkg: FSM state enum (IDLE, ISSUE, DRAIN), tag struct {valid, last, row, col}, width helper functions.
- One sub-module: matmul_tag_delay. It is a D-stage shift register of tags with async reset and handles D=1 generically.
- FSM and counters stay in matmul_dot_sched.

Test Plan:
- ROWS=2, COLS=3, RD_LATENCY=1, DOT_LATENCY=4, start at cycle 0 -> rd_en cycles 1-6 with (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); res_valid cycles 6-11 with same tags; done only at cycle 11; busy cycles 1-11.
- Same config, hold=1 in cycles 2-3 -> issues at 1,4,5,6,7,8; res_valid at 6,9,10,11,12,13; done at 13. With MATMUL_SCHED_PERF_EN: perf_stalls=2, perf_cycles=13.
- ROWS=1, COLS=1, start at 0 -> single rd_en at cycle 1 (0,0); res_valid and done at cycle 6.
- start re-pulsed at cycles 3 and 11 during a pass -> ignored, no extra issues. start at cycle 12 begins a new pass with rd_en at 13.
- rst asserted asynchronously at cycle 4 of a pass -> all outputs 0 immediately; no res_valid/done for discarded tags; a fresh start afterwards behaves as the first scenario.
